// File: rtl/rd_cpl_timeout_mon_if.sv
// Signal bundle for rd_cpl_timeout_mon: snooped TRN receive stream, read registration,
// retry handshake, abort notification and the pending-tag mask.
interface rd_cpl_timeout_mon_if #(
  parameter int NUM_TAGS = 8,
  parameter int TAG_W    = 3
);
  logic [63:0]         trn_rd;
  logic                trn_rsof_n;
  logic                trn_rsrc_rdy_n;
  logic                trn_rdst_rdy_n;
  logic                req_valid;
  logic [TAG_W-1:0]    req_tag;
  logic [63:0]         req_addr;
  logic [9:0]          req_dwords;
  logic                retry_valid;
  logic                retry_ack;
  logic [63:0]         retry_addr;
  logic [TAG_W-1:0]    retry_tag;
  logic [9:0]          retry_dwords;
  logic                abort_valid;
  logic [TAG_W-1:0]    abort_tag;
  logic [NUM_TAGS-1:0] pending_mask;

  modport master (
    output trn_rd, trn_rsof_n, trn_rsrc_rdy_n, trn_rdst_rdy_n,
    output req_valid, req_tag, req_addr, req_dwords, retry_ack,
    input  retry_valid, retry_addr, retry_tag, retry_dwords,
    input  abort_valid, abort_tag, pending_mask
  );

  modport slave (
    input  trn_rd, trn_rsof_n, trn_rsrc_rdy_n, trn_rdst_rdy_n,
    input  req_valid, req_tag, req_addr, req_dwords, retry_ack,
    output retry_valid, retry_addr, retry_tag, retry_dwords,
    output abort_valid, abort_tag, pending_mask
  );
endinterface

// File: rtl/rd_cpl_timeout_mon.sv
// Read-completion timeout monitor: tracks outstanding tags, snoops completions, re-issues stalled reads.
// Optional macro CPL_RETRY_LIMIT_EN caps retries at MAX_RETRIES and aborts exhausted tags.
module rd_cpl_timeout_mon #(
  parameter int NUM_TAGS    = 8,
  parameter int TAG_W       = 3,
  parameter int TIMEOUT_CYC = 8192,
  parameter int MAX_RETRIES = 3
) (
  input  logic                trn_clk,
  input  logic                reset_n,
  rd_cpl_timeout_mon_if.slave bus
);
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CHECK    = 2'd1;
  localparam logic [1:0] S_ISSUE    = 2'd2;
  localparam logic [1:0] S_WAIT_ACK = 2'd3;

  logic                hdr_seen_reg;
  logic [10:0]         cpl_len_reg;
  logic                beat, hdr_hit, cpl_fire;
  logic [TAG_W-1:0]    cpl_tag;

  logic                pending_reg [NUM_TAGS];
  logic [15:0]         cnt_reg     [NUM_TAGS];
  logic [63:0]         addr_reg    [NUM_TAGS];
  logic [10:0]         rem_reg     [NUM_TAGS];
  logic [NUM_TAGS-1:0] reg_hit, upd_hit, upd_done, issue_hit, kill_hit;

  logic [1:0]          state_reg;
  logic [TAG_W-1:0]    idx_reg, idx_inc;
  logic                retry_valid_reg;
  logic [63:0]         retry_addr_reg;
  logic [TAG_W-1:0]    retry_tag_reg;
  logic [9:0]          retry_dw_reg;
  logic                cur_pending, timed_out, abort_go;
  logic [15:0]         cur_cnt;

  // A completion is a two-beat pattern: matching header on SOF, tag on the following accepted beat.
  assign beat     = !bus.trn_rsrc_rdy_n && !bus.trn_rdst_rdy_n;
  assign hdr_hit  = beat && !bus.trn_rsof_n && (bus.trn_rd[62:56] == 7'b1001010)
                    && (bus.trn_rd[15:13] == 3'b000);
  assign cpl_fire = beat && hdr_seen_reg;
  assign cpl_tag  = bus.trn_rd[40 +: TAG_W];

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr_seen_reg <= 1'b0;
      cpl_len_reg  <= '0;
    end else if (beat) begin
      hdr_seen_reg <= hdr_hit && !hdr_seen_reg;
      if (hdr_hit && !hdr_seen_reg)
        cpl_len_reg <= {bus.trn_rd[41:32] == 10'd0, bus.trn_rd[41:32]};
    end
  end

  for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_tag
    assign reg_hit[gi]   = bus.req_valid && (bus.req_tag == TAG_W'(gi));
    assign upd_hit[gi]   = cpl_fire && (cpl_tag == TAG_W'(gi)) && pending_reg[gi] && !reg_hit[gi];
    assign upd_done[gi]  = cpl_len_reg >= rem_reg[gi];
    assign issue_hit[gi] = (state_reg == S_ISSUE) && (idx_reg == TAG_W'(gi)) && pending_reg[gi];
    assign kill_hit[gi]  = abort_go && (idx_reg == TAG_W'(gi));
    assign bus.pending_mask[gi] = pending_reg[gi];

    // Registration outranks everything; counter is zero whenever the tag is idle.
    always_ff @(posedge trn_clk or negedge reset_n) begin
      if (!reset_n) begin
        pending_reg[gi] <= 1'b0;
        cnt_reg[gi]     <= '0;
      end else if (reg_hit[gi]) begin
        pending_reg[gi] <= 1'b1;
        cnt_reg[gi]     <= '0;
      end else if (upd_hit[gi]) begin
        pending_reg[gi] <= !upd_done[gi];
        cnt_reg[gi]     <= '0;
      end else if (kill_hit[gi]) begin
        pending_reg[gi] <= 1'b0;
        cnt_reg[gi]     <= '0;
      end else if (issue_hit[gi]) begin
        cnt_reg[gi]     <= '0;
      end else if (pending_reg[gi] && (cnt_reg[gi] != 16'hFFFF)) begin
        cnt_reg[gi]     <= cnt_reg[gi] + 16'd1;
      end
    end

    always_ff @(posedge trn_clk) begin
      if (reg_hit[gi]) begin
        addr_reg[gi] <= bus.req_addr;
        rem_reg[gi]  <= {bus.req_dwords == 10'd0, bus.req_dwords};
      end else if (upd_hit[gi]) begin
        addr_reg[gi] <= addr_reg[gi] + {51'd0, cpl_len_reg, 2'b00};
        rem_reg[gi]  <= upd_done[gi] ? 11'd0 : rem_reg[gi] - cpl_len_reg;
      end
    end
  end

  assign cur_pending = pending_reg[idx_reg];
  assign cur_cnt     = cnt_reg[idx_reg];
  assign timed_out   = cur_pending && ({16'd0, cur_cnt} >= 32'(TIMEOUT_CYC));
  assign idx_inc     = idx_reg + TAG_W'(1);

`ifdef CPL_RETRY_LIMIT_EN
  localparam int RW = $clog2(MAX_RETRIES + 2);
  logic [RW-1:0]    retries_reg [NUM_TAGS];
  logic             abort_valid_reg;
  logic [TAG_W-1:0] abort_tag_reg;
  logic             unused_trn;

  for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_retry
    always_ff @(posedge trn_clk or negedge reset_n) begin
      if (!reset_n)                        retries_reg[gi] <= '0;
      else if (reg_hit[gi] || kill_hit[gi]) retries_reg[gi] <= '0;
      else if (issue_hit[gi])               retries_reg[gi] <= retries_reg[gi] + RW'(1);
    end
  end

  assign abort_go = (state_reg == S_CHECK) && timed_out
                    && (retries_reg[idx_reg] == RW'(MAX_RETRIES))
                    && !(bus.req_valid && (bus.req_tag == idx_reg));

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      abort_valid_reg <= 1'b0;
      abort_tag_reg   <= '0;
    end else begin
      abort_valid_reg <= abort_go;
      if (abort_go) abort_tag_reg <= idx_reg;
    end
  end

  assign bus.abort_valid = abort_valid_reg;
  assign bus.abort_tag   = abort_tag_reg;
  assign unused_trn      = ^bus.trn_rd;
`else
  logic unused_trn;
  assign abort_go        = 1'b0;
  assign bus.abort_valid = 1'b0;
  assign bus.abort_tag   = '0;
  assign unused_trn      = ^{bus.trn_rd, 32'(MAX_RETRIES)};
`endif

  // Scanner: one tag per IDLE cycle; a retry stays posted until acked, even if the tag completes.
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= S_IDLE;
      idx_reg         <= '0;
      retry_valid_reg <= 1'b0;
      retry_addr_reg  <= '0;
      retry_tag_reg   <= '0;
      retry_dw_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cur_pending) state_reg <= S_CHECK;
          else             idx_reg   <= idx_inc;
        end
        S_CHECK: begin
          if (abort_go) begin
            state_reg <= S_IDLE;
            idx_reg   <= idx_inc;
          end else if (timed_out) begin
            state_reg <= S_ISSUE;
          end else begin
            state_reg <= S_IDLE;
            idx_reg   <= idx_inc;
          end
        end
        S_ISSUE: begin
          if (cur_pending) begin
            retry_valid_reg <= 1'b1;
            retry_addr_reg  <= addr_reg[idx_reg];
            retry_tag_reg   <= idx_reg;
            retry_dw_reg    <= rem_reg[idx_reg][9:0];
            state_reg       <= S_WAIT_ACK;
          end else begin
            state_reg <= S_IDLE;
            idx_reg   <= idx_inc;
          end
        end
        S_WAIT_ACK: begin
          if (bus.retry_ack) begin
            retry_valid_reg <= 1'b0;
            state_reg       <= S_IDLE;
            idx_reg         <= idx_inc;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.retry_valid  = retry_valid_reg;
  assign bus.retry_addr   = retry_addr_reg;
  assign bus.retry_tag    = retry_tag_reg;
  assign bus.retry_dwords = retry_dw_reg;
endmodule

// File: tb/tb_rd_cpl_timeout_mon.sv
// Scoreboard bench for rd_cpl_timeout_mon: stimulus pushes expected retries/aborts,
// a negedge monitor pops and compares them; pending_mask checked inline.
module tb_rd_cpl_timeout_mon;
  localparam int NT = 8;
  localparam int TW = 3;
  localparam int TO = 64;
  localparam int MR = 3;

  typedef struct {
    bit          is_abort;
    logic [2:0]  tag;
    logic [63:0] addr;
    logic [9:0]  dw;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rd_cpl_timeout_mon_if #(.NUM_TAGS(NT), .TAG_W(TW)) bus ();

  rd_cpl_timeout_mon #(
    .NUM_TAGS(NT), .TAG_W(TW), .TIMEOUT_CYC(TO), .MAX_RETRIES(MR)
  ) dut (
    .trn_clk(clk),
    .reset_n(rst_n),
    .bus(bus)
  );

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          retry_seen = 0;
  int          abort_seen = 0;
  int          last_hold = 0;
  int          cur_hold = 0;
  int          ack_delay = 2;
  int          hc = 0;
  bit          prev_v = 0;
  bit          prev_ab = 0;
  bit          expect_drop = 0;
  logic [63:0] held_addr;
  logic [2:0]  held_tag;
  logic [9:0]  held_dw;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic register(input logic [2:0] tag, input logic [63:0] addr, input logic [9:0] dw);
    bus.req_valid  = 1'b1;
    bus.req_tag    = tag;
    bus.req_addr   = addr;
    bus.req_dwords = dw;
    @(negedge clk);
    bus.req_valid  = 1'b0;
  endtask

  task automatic drive_hdr(input logic [9:0] len, input logic [2:0] sub);
    bus.trn_rsrc_rdy_n = 1'b0;
    bus.trn_rdst_rdy_n = 1'b0;
    bus.trn_rsof_n     = 1'b0;
    bus.trn_rd         = 64'd0;
    bus.trn_rd[62:56]  = 7'b1001010;
    bus.trn_rd[41:32]  = len;
    bus.trn_rd[15:13]  = sub;
  endtask

  task automatic drive_tag(input logic [2:0] tag);
    bus.trn_rsof_n    = 1'b1;
    bus.trn_rd        = 64'd0;
    bus.trn_rd[42:40] = tag;
  endtask

  task automatic trn_idle();
    bus.trn_rsrc_rdy_n = 1'b1;
    bus.trn_rsof_n     = 1'b1;
    bus.trn_rd         = 64'd0;
  endtask

  task automatic send_cpl(input logic [2:0] tag, input logic [9:0] len, input logic [2:0] sub);
    drive_hdr(len, sub);
    @(negedge clk);
    drive_tag(tag);
    @(negedge clk);
    trn_idle();
  endtask

  task automatic push_exp(input bit ab, input logic [2:0] tag, input logic [63:0] addr, input logic [9:0] dw);
    exp_t e;
    e.is_abort = ab; e.tag = tag; e.addr = addr; e.dw = dw;
    exp_q.push_back(e);
  endtask

  // Retry responder: acks ack_delay cycles after retry_valid rises, driven away from the edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (bus.retry_ack) begin
        bus.retry_ack = 1'b0;
      end else if (bus.retry_valid && rst_n) begin
        if (hc >= ack_delay) begin
          bus.retry_ack = 1'b1;
          hc = 0;
        end else begin
          hc++;
        end
      end else begin
        hc = 0;
      end
    end
  end

  // Monitor: pops one expectation per retry rise / abort pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 0; prev_ab = 0; expect_drop = 0; cur_hold = 0;
      end else begin
        if (expect_drop) begin
          check_eq("retry_drop_after_ack", bus.retry_valid, 0);
          expect_drop = 0;
        end
        if (bus.retry_valid && !prev_v) begin
          retry_seen++;
          cur_hold  = 1;
          held_addr = bus.retry_addr; held_tag = bus.retry_tag; held_dw = bus.retry_dwords;
          $display("[TB] retry tag=%0d addr=0x%0h dwords=%0d", bus.retry_tag, bus.retry_addr, bus.retry_dwords);
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_retry: got tag %0d, expected no output", bus.retry_tag);
          end else begin
            e = exp_q.pop_front();
            check_eq("retry_kind", 0, {63'd0, e.is_abort});
            check_eq("retry_tag", bus.retry_tag, e.tag);
            check_eq("retry_addr", bus.retry_addr, e.addr);
            check_eq("retry_dwords", bus.retry_dwords, e.dw);
          end
        end else if (bus.retry_valid) begin
          cur_hold++;
          check_eq("retry_payload_stable", {bus.retry_addr, bus.retry_tag, bus.retry_dwords} == {held_addr, held_tag, held_dw}, 1);
        end else if (prev_v) begin
          last_hold = cur_hold;
        end
        if (bus.retry_valid && bus.retry_ack) expect_drop = 1;
        if (bus.abort_valid) begin
          abort_seen++;
          $display("[TB] abort tag=%0d", bus.abort_tag);
          check_eq("abort_pulse_width", prev_ab, 0);
          check_eq("abort_vs_retry_rise", bus.retry_valid && !prev_v, 0);
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_abort: got tag %0d, expected no output", bus.abort_tag);
          end else begin
            e = exp_q.pop_front();
            check_eq("abort_kind", 1, {63'd0, e.is_abort});
            check_eq("abort_tag", bus.abort_tag, e.tag);
          end
        end
        prev_v  = bus.retry_valid;
        prev_ab = bus.abort_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    bus.req_valid = 0; bus.req_tag = 0; bus.req_addr = 0; bus.req_dwords = 0;
    bus.retry_ack = 0;
    bus.trn_rdst_rdy_n = 1'b0;
    trn_idle();
    repeat (3) @(negedge clk);

    check_eq("rst_pending", bus.pending_mask, 0);
    check_eq("rst_retry_valid", bus.retry_valid, 0);
    check_eq("rst_abort_valid", bus.abort_valid, 0);
    check_eq("rst_retry_addr", bus.retry_addr, 0);
    check_eq("rst_retry_tag", bus.retry_tag, 0);
    check_eq("rst_retry_dwords", bus.retry_dwords, 0);
    check_eq("rst_abort_tag", bus.abort_tag, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Tag 2 completes in two halves; no retry afterwards.
    register(3'd2, 64'h1000, 10'd32);
    check_eq("t2_registered", bus.pending_mask, 8'h04);
    send_cpl(3'd2, 10'd16, 3'd0);
    check_eq("t2_half_done", bus.pending_mask, 8'h04);
    send_cpl(3'd2, 10'd16, 3'd0);
    check_eq("t2_complete", bus.pending_mask, 8'h00);
    repeat (TO + 40) @(negedge clk);
    check_eq("t2_no_retry", retry_seen, 0);

    // Same-cycle registration and update for tag 1: registration wins, remaining stays 8.
    register(3'd1, 64'h3000, 10'd8);
    drive_hdr(10'd4, 3'd0);
    @(negedge clk);
    drive_tag(3'd1);
    bus.req_valid = 1'b1; bus.req_tag = 3'd1; bus.req_addr = 64'h3000; bus.req_dwords = 10'd8;
    @(negedge clk);
    bus.req_valid = 1'b0;
    trn_idle();
    check_eq("t1_after_collision", bus.pending_mask, 8'h02);
    send_cpl(3'd1, 10'd7, 3'd0);
    check_eq("t1_rem_after_7", bus.pending_mask, 8'h02);
    send_cpl(3'd1, 10'd1, 3'd0);
    check_eq("t1_rem_after_8", bus.pending_mask, 8'h00);

    // Oversized completion saturates; 0 dwords means 1024; bad header and idle tags ignored.
    register(3'd6, 64'h6000, 10'd4);
    send_cpl(3'd6, 10'd16, 3'd0);
    check_eq("t6_oversize_clears", bus.pending_mask, 8'h00);
    register(3'd0, 64'h0, 10'd0);
    send_cpl(3'd0, 10'd512, 3'd0);
    check_eq("t0_1024_half", bus.pending_mask, 8'h01);
    send_cpl(3'd0, 10'd512, 3'd0);
    check_eq("t0_1024_done", bus.pending_mask, 8'h00);
    register(3'd3, 64'h3300, 10'd4);
    send_cpl(3'd3, 10'd4, 3'd1);
    check_eq("t3_bad_hdr_ignored", bus.pending_mask, 8'h08);
    send_cpl(3'd4, 10'd4, 3'd0);
    check_eq("t4_unpending_ignored", bus.pending_mask, 8'h08);
    send_cpl(3'd3, 10'd4, 3'd0);
    check_eq("t3_done", bus.pending_mask, 8'h00);

    // Tag 5 stalls after 16 of 64 dwords; retry held 10+ cycles; completion during WAIT_ACK.
    ack_delay = 10;
    register(3'd5, 64'h2000, 10'd64);
    send_cpl(3'd5, 10'd16, 3'd0);
    push_exp(0, 3'd5, 64'h2040, 10'd48);
    cyc = 0;
    while (!bus.retry_valid && cyc < TO + 40) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t5_retry_seen", bus.retry_valid, 1);
    check_eq("t5_latency_ge_timeout", cyc >= TO, 1);
    send_cpl(3'd5, 10'd48, 3'd0);
    check_eq("t5_cpl_in_wait_clears", bus.pending_mask, 8'h00);
    check_eq("t5_retry_not_withdrawn", bus.retry_valid, 1);
    cyc = 0;
    while (bus.retry_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check_eq("t5_retry_dropped", bus.retry_valid, 0);
    check_eq("t5_hold_ge_10", last_hold >= 10, 1);
    check_eq("t5_single_retry", retry_seen, 1);

    // Tag 7 never completes.
    ack_delay = 2;
    base = retry_seen;
    register(3'd7, 64'h7000, 10'd4);
`ifdef CPL_RETRY_LIMIT_EN
    for (int i = 0; i < MR; i++) push_exp(0, 3'd7, 64'h7000, 10'd4);
    push_exp(1, 3'd7, 64'h0, 10'd0);
    cyc = 0;
    while (abort_seen == 0 && cyc < 6 * (TO + 40)) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check_eq("t7_abort_count", abort_seen, 1);
    check_eq("t7_retry_count", retry_seen - base, MR);
    check_eq("t7_pending_cleared", bus.pending_mask, 8'h00);
    repeat (TO + 40) @(negedge clk);
    check_eq("t7_no_more_retries", retry_seen - base, MR);
`else
    for (int i = 0; i < MR + 1; i++) push_exp(0, 3'd7, 64'h7000, 10'd4);
    cyc = 0;
    while (!((retry_seen - base) >= MR + 1 && !bus.retry_valid) && cyc < 6 * (TO + 40)) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t7_unlimited_retries", retry_seen - base, MR + 1);
    check_eq("t7_still_pending", bus.pending_mask, 8'h80);
    send_cpl(3'd7, 10'd4, 3'd0);
    check_eq("t7_done", bus.pending_mask, 8'h00);
    check_eq("t7_no_abort", abort_seen, 0);
`endif

    // Reset during WAIT_ACK drops retry_valid and pending without a clock edge.
    ack_delay = 1000;
    register(3'd3, 64'h5000, 10'd16);
    push_exp(0, 3'd3, 64'h5000, 10'd16);
    cyc = 0;
    while (!bus.retry_valid && cyc < TO + 40) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t3_wait_ack_reached", bus.retry_valid, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_retry_valid", bus.retry_valid, 0);
    check_eq("async_rst_pending", bus.pending_mask, 0);
    check_eq("async_rst_retry_addr", bus.retry_addr, 0);
    check_eq("async_rst_retry_tag", bus.retry_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 2;
    @(negedge clk);
    send_cpl(3'd4, 10'd8, 3'd0);
    check_eq("post_rst_unreg_cpl", bus.pending_mask, 0);
    send_cpl(3'd3, 10'd16, 3'd0);
    check_eq("post_rst_old_tag_cpl", bus.pending_mask, 0);
    repeat (5) @(negedge clk);
    check_eq("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
